// File: rtl/shift_register_universal.sv
// Universal WIDTH-bit register: hold, shift/rotate both ways, load, complement, clear,
// with a separately registered complement output and a saturating shift-step counter.
module shift_register_universal #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SR_IN,
    input  logic             SL_IN,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             SO_R,
    output logic             SO_L,
    output logic [CNT_W-1:0] SHIFT_CNT,
    output logic             ZERO
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_CPL   = 3'b110;
    localparam logic [2:0] MODE_CLR   = 3'b111;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] qn_reg;
    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic move_right;
    logic move_left;

    assign move_right = (MODE == MODE_SHR) || (MODE == MODE_ROR);
    assign move_left  = (MODE == MODE_SHL) || (MODE == MODE_ROL);

    // Each bit picks its neighbour; only the end bits choose between serial input and wrap-around.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic from_upper;
            logic from_lower;

            if (gi == WIDTH - 1) begin : g_msb
                assign from_upper = (MODE == MODE_ROR) ? q_reg[0] : SR_IN;
            end else begin : g_mid_upper
                assign from_upper = q_reg[gi+1];
            end

            if (gi == 0) begin : g_lsb
                assign from_lower = (MODE == MODE_ROL) ? q_reg[WIDTH-1] : SL_IN;
            end else begin : g_mid_lower
                assign from_lower = q_reg[gi-1];
            end

            assign q_next[gi] = move_right          ? from_upper :
                                move_left           ? from_lower :
                                (MODE == MODE_LOAD) ? D[gi]      :
                                (MODE == MODE_CPL)  ? ~q_reg[gi] :
                                (MODE == MODE_CLR)  ? 1'b0       :
                                                      q_reg[gi];
        end
    endgenerate

    always_comb begin
        cnt_next = cnt_reg;
        case (MODE)
            MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL: begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            MODE_LOAD, MODE_CLR: cnt_next = '0;
            MODE_HOLD, MODE_CPL: cnt_next = cnt_reg;
            default:             cnt_next = cnt_reg;
        endcase
    end

    // QN gets its own flops, loaded from the complement of the same next value as Q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_reg   <= RESET_VALUE;
            qn_reg  <= ~RESET_VALUE;
            cnt_reg <= '0;
        end else if (EN) begin
            q_reg   <= q_next;
            qn_reg  <= ~q_next;
            cnt_reg <= cnt_next;
        end
    end

    assign Q         = q_reg;
    assign QN        = qn_reg;
    assign SO_R      = q_reg[0];
    assign SO_L      = q_reg[WIDTH-1];
    assign SHIFT_CNT = cnt_reg;
    assign ZERO      = (q_reg == '0);

endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for shift_register_universal: directed scenarios on an 8-bit and a 2-bit instance,
// then a random run against an arithmetic reference model.
module tb_shift_register_universal;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 8-bit instance, RESET_VALUE = 3C
    logic       rst_a, en_a, sr_a, sl_a;
    logic [2:0] mode_a;
    logic [7:0] d_a, q_a, qn_a;
    logic       so_r_a, so_l_a, zero_a;
    logic [3:0] cnt_a;

    // 2-bit instance, RESET_VALUE = 0
    logic       rst_b, en_b, sr_b, sl_b;
    logic [2:0] mode_b;
    logic [1:0] d_b, q_b, qn_b;
    logic       so_r_b, so_l_b, zero_b;
    logic [1:0] cnt_b;

    shift_register_universal #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut_a (
        .CLK(clk), .RST(rst_a), .EN(en_a), .MODE(mode_a), .D(d_a),
        .SR_IN(sr_a), .SL_IN(sl_a), .Q(q_a), .QN(qn_a), .SO_R(so_r_a),
        .SO_L(so_l_a), .SHIFT_CNT(cnt_a), .ZERO(zero_a)
    );

    shift_register_universal #(.WIDTH(2), .RESET_VALUE(2'b00)) dut_b (
        .CLK(clk), .RST(rst_b), .EN(en_b), .MODE(mode_b), .D(d_b),
        .SR_IN(sr_b), .SL_IN(sl_b), .Q(q_b), .QN(qn_b), .SO_R(so_r_b),
        .SO_L(so_l_b), .SHIFT_CNT(cnt_b), .ZERO(zero_b)
    );

    // Reference model: register value treated as an unsigned number of w bits.
    function automatic logic [31:0] ref_next(input int w, input logic [31:0] q, input logic [2:0] m,
                                             input logic [31:0] d, input logic sr, input logic sl);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (32'h1 << w) - 32'h1;
        case (m)
            3'd1:    r = (q >> 1) | (32'(sr) << (w - 1));
            3'd2:    r = (q << 1) | 32'(sl);
            3'd3:    r = d;
            3'd4:    r = (q >> 1) | ((q & 32'h1) << (w - 1));
            3'd5:    r = (q << 1) | (q >> (w - 1));
            3'd6:    r = ~q;
            3'd7:    r = 32'h0;
            default: r = q;
        endcase
        return r & mask;
    endfunction

    function automatic int ref_cnt(input int w, input int c, input logic [2:0] m);
        if (m == 3'd1 || m == 3'd2 || m == 3'd4 || m == 3'd5) return (c < w) ? c + 1 : w;
        if (m == 3'd3 || m == 3'd7) return 0;
        return c;
    endfunction

    task automatic step_a(input logic r, input logic e, input logic [2:0] m,
                          input logic [7:0] d, input logic sr, input logic sl);
        rst_a = r; en_a = e; mode_a = m; d_a = d; sr_a = sr; sl_a = sl;
        @(posedge clk);
        #1;
        $display("A: rst=%b en=%b mode=%0d d=%h sr=%b sl=%b -> q=%h qn=%h cnt=%0d zero=%b",
                 r, e, m, d, sr, sl, q_a, qn_a, cnt_a, zero_a);
    endtask

    task automatic step_b(input logic r, input logic e, input logic [2:0] m,
                          input logic [1:0] d, input logic sr, input logic sl);
        rst_b = r; en_b = e; mode_b = m; d_b = d; sr_b = sr; sl_b = sl;
        @(posedge clk);
        #1;
        $display("B: rst=%b en=%b mode=%0d d=%b sr=%b sl=%b -> q=%b qn=%b cnt=%0d zero=%b",
                 r, e, m, d, sr, sl, q_b, qn_b, cnt_b, zero_b);
    endtask

    task automatic test_reset;
        step_a(1'b1, 1'b1, 3'd3, 8'hFF, 1'b0, 1'b0);
        checks++; if (q_a !== 8'h3C) begin errors++; $display("FAIL reset_q: got %h expected 3c", q_a); end
        checks++; if (qn_a !== 8'hC3) begin errors++; $display("FAIL reset_qn: got %h expected c3", qn_a); end
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_a); end
        checks++; if (zero_a !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero_a); end
    endtask

    task automatic test_load_shift;
        step_a(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0);
        checks++; if (q_a !== 8'hA5) begin errors++; $display("FAIL load_q: got %h expected a5", q_a); end
        checks++; if (qn_a !== 8'h5A) begin errors++; $display("FAIL load_qn: got %h expected 5a", qn_a); end
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL load_cnt: got %0d expected 0", cnt_a); end
        step_a(1'b0, 1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
        checks++; if (q_a !== 8'hD2) begin errors++; $display("FAIL shr_q: got %h expected d2", q_a); end
        checks++; if (cnt_a !== 4'd1) begin errors++; $display("FAIL shr_cnt: got %0d expected 1", cnt_a); end
        checks++; if (so_r_a !== 1'b0) begin errors++; $display("FAIL shr_so_r: got %b expected 0", so_r_a); end
        step_a(1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        checks++; if (q_a !== 8'hA4) begin errors++; $display("FAIL shl_q: got %h expected a4", q_a); end
        checks++; if (cnt_a !== 4'd2) begin errors++; $display("FAIL shl_cnt: got %0d expected 2", cnt_a); end
        checks++; if (so_l_a !== 1'b1) begin errors++; $display("FAIL shl_so_l: got %b expected 1", so_l_a); end
    endtask

    task automatic test_rotate_saturation;
        step_a(1'b0, 1'b1, 3'd3, 8'h81, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        checks++; if (q_a !== 8'hC0) begin errors++; $display("FAIL ror_q: got %h expected c0", q_a); end
        step_a(1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
        checks++; if (q_a !== 8'h81) begin errors++; $display("FAIL rol_q: got %h expected 81", q_a); end
        for (int i = 1; i <= 9; i++) begin
            step_a(1'b0, 1'b1, 3'd4, 8'h00, 1'b1, 1'b1);
            checks++;
            if (cnt_a !== 4'((2 + i > 8) ? 8 : 2 + i)) begin
                errors++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", i, cnt_a, (2 + i > 8) ? 8 : 2 + i);
            end
        end
        checks++; if (q_a !== 8'hC0) begin errors++; $display("FAIL ror9_q: got %h expected c0", q_a); end
    endtask

    task automatic test_enable;
        step_a(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
        step_a(1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, 3'd3, 8'hFF, 1'b1, 1'b1);
        checks++; if (q_a !== 8'hA5) begin errors++; $display("FAIL en_hold_q: got %h expected a5", q_a); end
        checks++; if (qn_a !== 8'h5A) begin errors++; $display("FAIL en_hold_qn: got %h expected 5a", qn_a); end
        checks++; if (cnt_a !== 4'd2) begin errors++; $display("FAIL en_hold_cnt: got %0d expected 2", cnt_a); end
        step_a(1'b0, 1'b1, 3'd3, 8'hFF, 1'b0, 1'b0);
        checks++; if (q_a !== 8'hFF) begin errors++; $display("FAIL en_load_q: got %h expected ff", q_a); end
    endtask

    task automatic test_complement_clear;
        // 2D rotated right three times is A5, leaving the counter at 3
        step_a(1'b0, 1'b1, 3'd3, 8'h2D, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        checks++; if (q_a !== 8'hA5) begin errors++; $display("FAIL pre_cpl_q: got %h expected a5", q_a); end
        step_a(1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        checks++; if (q_a !== 8'h5A) begin errors++; $display("FAIL cpl_q: got %h expected 5a", q_a); end
        checks++; if (qn_a !== 8'hA5) begin errors++; $display("FAIL cpl_qn: got %h expected a5", qn_a); end
        checks++; if (cnt_a !== 4'd3) begin errors++; $display("FAIL cpl_cnt: got %0d expected 3", cnt_a); end
        step_a(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        checks++; if (q_a !== 8'h00) begin errors++; $display("FAIL clr_q: got %h expected 00", q_a); end
        checks++; if (zero_a !== 1'b1) begin errors++; $display("FAIL clr_zero: got %b expected 1", zero_a); end
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL clr_cnt: got %0d expected 0", cnt_a); end
        step_a(1'b0, 1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
        step_a(1'b1, 1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
        checks++; if (q_a !== 8'h3C) begin errors++; $display("FAIL rst_pri_q: got %h expected 3c", q_a); end
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL rst_pri_cnt: got %0d expected 0", cnt_a); end
    endtask

    task automatic test_width2;
        step_b(1'b1, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0);
        step_b(1'b0, 1'b1, 3'd2, 2'b00, 1'b0, 1'b1);
        checks++; if (q_b !== 2'b01) begin errors++; $display("FAIL w2_shl1_q: got %b expected 01", q_b); end
        step_b(1'b0, 1'b1, 3'd2, 2'b00, 1'b0, 1'b1);
        checks++; if (q_b !== 2'b11) begin errors++; $display("FAIL w2_shl2_q: got %b expected 11", q_b); end
        checks++; if (cnt_b !== 2'd2) begin errors++; $display("FAIL w2_shl2_cnt: got %0d expected 2", cnt_b); end
        step_b(1'b0, 1'b1, 3'd4, 2'b00, 1'b0, 1'b0);
        checks++; if (q_b !== 2'b11) begin errors++; $display("FAIL w2_ror_q: got %b expected 11", q_b); end
        checks++; if (cnt_b !== 2'd2) begin errors++; $display("FAIL w2_ror_cnt: got %0d expected 2", cnt_b); end
        step_b(1'b0, 1'b1, 3'd6, 2'b00, 1'b0, 1'b0);
        checks++; if (q_b !== 2'b00) begin errors++; $display("FAIL w2_cpl_q: got %b expected 00", q_b); end
        checks++; if (qn_b !== 2'b11) begin errors++; $display("FAIL w2_cpl_qn: got %b expected 11", qn_b); end
        checks++; if (zero_b !== 1'b1) begin errors++; $display("FAIL w2_cpl_zero: got %b expected 1", zero_b); end
    endtask

    task automatic test_random;
        logic [31:0] mq_a, mq_b;
        int          mc_a, mc_b;
        logic        r, e, sr, sl;
        logic [2:0]  m;
        logic [7:0]  d;
        step_a(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step_b(1'b1, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0);
        mq_a = 32'h3C; mc_a = 0;
        mq_b = 32'h0;  mc_b = 0;
        for (int i = 0; i < 200; i++) begin
            r  = ($urandom_range(15) == 0);
            e  = ($urandom_range(4) != 0);
            m  = 3'($urandom_range(7));
            d  = 8'($urandom);
            sr = 1'($urandom);
            sl = 1'($urandom);
            rst_b = r; en_b = e; mode_b = m; d_b = d[1:0]; sr_b = sr; sl_b = sl;
            step_a(r, e, m, d, sr, sl);
            if (r) begin
                mq_a = 32'h3C; mc_a = 0; mq_b = 32'h0; mc_b = 0;
            end else if (e) begin
                mq_a = ref_next(8, mq_a, m, 32'(d), sr, sl);
                mc_a = ref_cnt(8, mc_a, m);
                mq_b = ref_next(2, mq_b, m, 32'(d[1:0]), sr, sl);
                mc_b = ref_cnt(2, mc_b, m);
            end
            checks++; if (q_a !== mq_a[7:0]) begin errors++; $display("FAIL rnd_a_q[%0d]: got %h expected %h", i, q_a, mq_a[7:0]); end
            checks++; if (qn_a !== ~mq_a[7:0]) begin errors++; $display("FAIL rnd_a_qn[%0d]: got %h expected %h", i, qn_a, ~mq_a[7:0]); end
            checks++; if (cnt_a !== 4'(mc_a)) begin errors++; $display("FAIL rnd_a_cnt[%0d]: got %0d expected %0d", i, cnt_a, mc_a); end
            checks++; if (zero_a !== (mq_a == 0)) begin errors++; $display("FAIL rnd_a_zero[%0d]: got %b expected %b", i, zero_a, mq_a == 0); end
            checks++; if ({so_l_a, so_r_a} !== {mq_a[7], mq_a[0]}) begin errors++; $display("FAIL rnd_a_so[%0d]: got %b%b expected %b%b", i, so_l_a, so_r_a, mq_a[7], mq_a[0]); end
            checks++; if (q_b !== mq_b[1:0]) begin errors++; $display("FAIL rnd_b_q[%0d]: got %b expected %b", i, q_b, mq_b[1:0]); end
            checks++; if (qn_b !== ~mq_b[1:0]) begin errors++; $display("FAIL rnd_b_qn[%0d]: got %b expected %b", i, qn_b, ~mq_b[1:0]); end
            checks++; if (cnt_b !== 2'(mc_b)) begin errors++; $display("FAIL rnd_b_cnt[%0d]: got %0d expected %0d", i, cnt_b, mc_b); end
            checks++; if (zero_b !== (mq_b == 0)) begin errors++; $display("FAIL rnd_b_zero[%0d]: got %b expected %b", i, zero_b, mq_b == 0); end
        end
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b0; mode_a = 3'd0; d_a = 8'h00; sr_a = 1'b0; sl_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b0; mode_b = 3'd0; d_b = 2'b00; sr_b = 1'b0; sl_b = 1'b0;
        #2;
        test_reset();
        test_load_shift();
        test_rotate_saturation();
        test_enable();
        test_complement_clear();
        test_width2();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
